// File: rtl/aemb2_cwb_pkg.sv
// Shared constants for the CWB/FSL FIFO responder: FSM encoding, TGA bit
// positions and the FIFO entry layout.
package aemb2_cwb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   localparam int TGA_NB  = 0;
   localparam int TGA_CTL = 1;

   localparam int ENTRY_W = 33;

   typedef struct packed {
      logic        ctl;
      logic [31:0] dat;
   } cwbEntry_t;

endpackage

// File: rtl/aemb2_sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty come from the count
// at the start of the cycle, so a simultaneous pop never unblocks a push.
module aemb2_sync_fifo #(
   parameter int W  = 33,
   parameter int AW = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push,
   input  logic [W-1:0]  pushDat,
   input  logic          pop,
   output logic [W-1:0]  headDat,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0] DEPTH = (AW+1)'(1) << AW;

   logic [W-1:0]  mem [2**AW];
   logic [AW-1:0] wrPtrReg;
   logic [AW-1:0] rdPtrReg;
   logic [AW:0]   countReg;
   logic          pushOk;
   logic          popOk;

   assign full    = (countReg == DEPTH);
   assign empty   = (countReg == '0);
   assign count   = countReg;
   assign pushOk  = push & ~full;
   assign popOk   = pop & ~empty;
   assign headDat = mem[rdPtrReg];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtrReg <= '0;
         rdPtrReg <= '0;
         countReg <= '0;
      end else begin
         if (pushOk) wrPtrReg <= wrPtrReg + AW'(1);
         if (popOk)  rdPtrReg <= rdPtrReg + AW'(1);
         case ({pushOk, popOk})
            2'b10:   countReg <= countReg + (AW+1)'(1);
            2'b01:   countReg <= countReg - (AW+1)'(1);
            default: countReg <= countReg;
         endcase
      end
   end

   // Storage is not reset; clearing the pointers is enough to discard it.
   always_ff @(posedge clk_i) begin
      if (pushOk) mem[wrPtrReg] <= pushDat;
   end

endmodule

// File: rtl/aemb2_cwb_fifo_slave.sv
// CWB/FSL responder: core puts fill the TX FIFO toward the accelerator, core
// gets drain the RX FIFO filled by the accelerator.
module aemb2_cwb_fifo_slave
   import aemb2_cwb_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          cwb_stb_i,
   input  logic          cwb_wre_i,
   input  logic [1:0]    cwb_tga_i,
   input  logic [31:0]   cwb_dat_i,
   output logic [31:0]   cwb_dat_o,
   output logic          cwb_ack_o,
   output logic          cwb_err_o,
   output logic [31:0]   tx_dat_o,
   output logic          tx_ctl_o,
   output logic          tx_vld_o,
   input  logic          tx_rdy_i,
   input  logic [31:0]   rx_dat_i,
   input  logic          rx_ctl_i,
   input  logic          rx_vld_i,
   output logic          rx_rdy_o,
   output logic [AW:0]   tx_cnt_o,
   output logic [AW:0]   rx_cnt_o
);

   logic [1:0]  stateReg, stateNext;
   logic        errReg, errNext;
   logic [31:0] datReg, datNext;
   logic        txPush, rxPop;
   logic        txFull, txEmpty, rxFull, rxEmpty;
   logic        nbAllowed;
   cwbEntry_t   txHead, rxHead;

   aemb2_sync_fifo #(.W(ENTRY_W), .AW(AW)) txFifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push    (txPush),
      .pushDat ({cwb_tga_i[TGA_CTL], cwb_dat_i}),
      .pop     (tx_vld_o & tx_rdy_i),
      .headDat (txHead),
      .full    (txFull),
      .empty   (txEmpty),
      .count   (tx_cnt_o)
   );

   aemb2_sync_fifo #(.W(ENTRY_W), .AW(AW)) rxFifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push    (rx_vld_i & rx_rdy_o),
      .pushDat ({rx_ctl_i, rx_dat_i}),
      .pop     (rxPop),
      .headDat (rxHead),
      .full    (rxFull),
      .empty   (rxEmpty),
      .count   (rx_cnt_o)
   );

   assign tx_dat_o  = txHead.dat;
   assign tx_ctl_o  = txHead.ctl;
   assign tx_vld_o  = ~txEmpty;
   assign rx_rdy_o  = ~rxFull;
   assign cwb_ack_o = (stateReg == ST_ACK);
   assign cwb_err_o = errReg;
   assign cwb_dat_o = datReg;

   // Only a fresh request from IDLE may fail fast; once stalled it waits.
   assign nbAllowed = (stateReg == ST_IDLE) & cwb_tga_i[TGA_NB];

   always_comb begin
      stateNext = stateReg;
      errNext   = errReg;
      datNext   = datReg;
      txPush    = 1'b0;
      rxPop     = 1'b0;
      case (stateReg)
         ST_IDLE, ST_WAIT: begin
            if (cwb_stb_i) begin
               if (cwb_wre_i) begin
                  if (!txFull) begin
                     txPush    = 1'b1;
                     errNext   = 1'b0;
                     stateNext = ST_ACK;
                  end else if (nbAllowed) begin
                     errNext   = 1'b1;
                     stateNext = ST_ACK;
                  end else begin
                     stateNext = ST_WAIT;
                  end
               end else begin
                  if (!rxEmpty) begin
                     rxPop     = 1'b1;
                     datNext   = rxHead.dat;
                     errNext   = (rxHead.ctl != cwb_tga_i[TGA_CTL]);
                     stateNext = ST_ACK;
                  end else if (nbAllowed) begin
                     datNext   = 32'h0;
                     errNext   = 1'b1;
                     stateNext = ST_ACK;
                  end else begin
                     stateNext = ST_WAIT;
                  end
               end
            end
         end
         ST_ACK:  stateNext = ST_IDLE;
         default: stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stateReg <= ST_IDLE;
         errReg   <= 1'b0;
         datReg   <= 32'h0;
      end else begin
         stateReg <= stateNext;
         errReg   <= errNext;
         datReg   <= datNext;
      end
   end

endmodule

// File: tb/tb_aemb2_cwb_fifo_slave.sv
// Directed bench for aemb2_cwb_fifo_slave (AW=2): bus responses are checked
// against a scoreboard queue filled when each request is issued.
module tb_aemb2_cwb_fifo_slave;

   localparam int AW = 2;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          cwb_stb_i = 1'b0;
   logic          cwb_wre_i = 1'b0;
   logic [1:0]    cwb_tga_i = 2'b00;
   logic [31:0]   cwb_dat_i = 32'h0;
   logic [31:0]   cwb_dat_o;
   logic          cwb_ack_o;
   logic          cwb_err_o;
   logic [31:0]   tx_dat_o;
   logic          tx_ctl_o;
   logic          tx_vld_o;
   logic          tx_rdy_i = 1'b0;
   logic [31:0]   rx_dat_i = 32'h0;
   logic          rx_ctl_i = 1'b0;
   logic          rx_vld_i = 1'b0;
   logic          rx_rdy_o;
   logic [AW:0]   tx_cnt_o;
   logic [AW:0]   rx_cnt_o;

   aemb2_cwb_fifo_slave #(.AW(AW)) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .cwb_stb_i (cwb_stb_i),
      .cwb_wre_i (cwb_wre_i),
      .cwb_tga_i (cwb_tga_i),
      .cwb_dat_i (cwb_dat_i),
      .cwb_dat_o (cwb_dat_o),
      .cwb_ack_o (cwb_ack_o),
      .cwb_err_o (cwb_err_o),
      .tx_dat_o  (tx_dat_o),
      .tx_ctl_o  (tx_ctl_o),
      .tx_vld_o  (tx_vld_o),
      .tx_rdy_i  (tx_rdy_i),
      .rx_dat_i  (rx_dat_i),
      .rx_ctl_i  (rx_ctl_i),
      .rx_vld_i  (rx_vld_i),
      .rx_rdy_o  (rx_rdy_o),
      .tx_cnt_o  (tx_cnt_o),
      .rx_cnt_o  (rx_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        err;
      logic [31:0] dat;
      logic        chkDat;
      int          lat;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   logic [32:0] txExp[$];
   int          nVec = 0;
   int          nMis = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nMis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue a bus request; expected response goes to the scoreboard now.
   task automatic startReq(input logic wre, input logic [1:0] tga, input logic [31:0] dat,
                           input logic eErr, input logic [31:0] eDat, input logic chkDat,
                           input int lat, input string tag);
      exp_t e;
      e.err = eErr; e.dat = eDat; e.chkDat = chkDat; e.lat = lat; e.tag = tag;
      sb.push_back(e);
      if (wre && !eErr) txExp.push_back({tga[1], dat});
      @(posedge clk_i); #1;
      cwb_stb_i = 1'b1;
      cwb_wre_i = wre;
      cwb_tga_i = tga;
      cwb_dat_i = dat;
   endtask

   // Wait (bounded) for ack, compare with the scoreboard head, release stb.
   task automatic waitAck(input int budget);
      exp_t e;
      int   lat;
      bit   seen;
      e = sb.pop_front();
      lat = 0;
      seen = 0;
      while (!seen && lat < budget) begin
         @(negedge clk_i);
         lat++;
         if (cwb_ack_o) seen = 1;
      end
      chk({e.tag, "_ack"}, 32'(cwb_ack_o), 32'd1);
      if (seen) begin
         chk({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
         chk({e.tag, "_err"}, 32'(cwb_err_o), 32'(e.err));
         if (e.chkDat) chk({e.tag, "_dat"}, cwb_dat_o, e.dat);
         $display("xfer %s: lat=%0d err=%0b dat=%h", e.tag, lat, cwb_err_o, cwb_dat_o);
      end
      @(posedge clk_i); #1;
      cwb_stb_i = 1'b0;
      @(negedge clk_i);
      chk({e.tag, "_ack_1cyc"}, 32'(cwb_ack_o), 32'd0);
   endtask

   task automatic pushRx(input logic ctl, input logic [31:0] dat);
      @(posedge clk_i); #1;
      rx_vld_i = 1'b1;
      rx_ctl_i = ctl;
      rx_dat_i = dat;
      @(posedge clk_i); #1;
      rx_vld_i = 1'b0;
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_ack", 32'(cwb_ack_o), 32'd0);
      chk("rst_err", 32'(cwb_err_o), 32'd0);
      chk("rst_dat", cwb_dat_o, 32'h0);
      chk("rst_txvld", 32'(tx_vld_o), 32'd0);
      chk("rst_rxrdy", 32'(rx_rdy_o), 32'd1);
      chk("rst_txcnt", 32'(tx_cnt_o), 32'd0);
      chk("rst_rxcnt", 32'(rx_cnt_o), 32'd0);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;

      // First blocking put, stream side stalled
      startReq(1'b1, 2'b10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 2, "put0");
      waitAck(10);
      chk("put0_txcnt", 32'(tx_cnt_o), 32'd1);
      chk("put0_txdat", tx_dat_o, 32'hDEADBEEF);
      chk("put0_txctl", 32'(tx_ctl_o), 32'd1);
      chk("put0_txvld", 32'(tx_vld_o), 32'd1);

      // Fill to depth 4
      startReq(1'b1, 2'b10, 32'h11111111, 1'b0, 32'h0, 1'b0, 2, "put1");
      waitAck(10);
      startReq(1'b1, 2'b00, 32'h22222222, 1'b0, 32'h0, 1'b0, 2, "put2");
      waitAck(10);
      startReq(1'b1, 2'b10, 32'h33333333, 1'b0, 32'h0, 1'b0, 2, "put3");
      waitAck(10);
      chk("full_txcnt", 32'(tx_cnt_o), 32'd4);

      // Non-blocking put on full TX fails without pushing
      startReq(1'b1, 2'b01, 32'h55555555, 1'b1, 32'h0, 1'b0, 2, "put_nb_full");
      waitAck(10);
      chk("nbfull_txcnt", 32'(tx_cnt_o), 32'd4);

      // Blocking put on full TX stalls until the accelerator takes one entry
      startReq(1'b1, 2'b00, 32'h44444444, 1'b0, 32'h0, 1'b0, 2, "put4_blk");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         chk("put4_stall_ack", 32'(cwb_ack_o), 32'd0);
      end
      chk("put4_stall_txcnt", 32'(tx_cnt_o), 32'd4);
      @(posedge clk_i); #1;
      tx_rdy_i = 1'b1;
      void'(txExp.pop_front());
      @(posedge clk_i); #1;
      tx_rdy_i = 1'b0;
      waitAck(10);
      chk("put4_txcnt", 32'(tx_cnt_o), 32'd4);

      // Drain TX and check order/control bits
      @(posedge clk_i); #1;
      tx_rdy_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         logic [32:0] h;
         h = txExp.pop_front();
         @(negedge clk_i);
         chk("drain_vld", 32'(tx_vld_o), 32'd1);
         chk("drain_dat", tx_dat_o, h[31:0]);
         chk("drain_ctl", 32'(tx_ctl_o), 32'(h[32]));
         $display("drain: dat=%h ctl=%0b", tx_dat_o, tx_ctl_o);
      end
      @(posedge clk_i); #1;
      tx_rdy_i = 1'b0;
      @(negedge clk_i);
      chk("drain_empty_vld", 32'(tx_vld_o), 32'd0);
      chk("drain_empty_cnt", 32'(tx_cnt_o), 32'd0);

      // Non-blocking get on empty RX
      startReq(1'b0, 2'b01, 32'h0, 1'b1, 32'h0, 1'b1, 2, "get_nb_empty");
      waitAck(10);
      chk("nbempty_rxcnt", 32'(rx_cnt_o), 32'd0);

      // Control-bit mismatch, then match
      pushRx(1'b0, 32'h12345678);
      @(negedge clk_i);
      chk("rx1_cnt", 32'(rx_cnt_o), 32'd1);
      startReq(1'b0, 2'b10, 32'h0, 1'b1, 32'h12345678, 1'b1, 2, "get_mismatch");
      waitAck(10);
      chk("mismatch_rxcnt", 32'(rx_cnt_o), 32'd0);
      pushRx(1'b1, 32'h9ABCDEF0);
      startReq(1'b0, 2'b10, 32'h0, 1'b0, 32'h9ABCDEF0, 1'b1, 2, "get_match");
      waitAck(10);

      // Blocking get on empty RX, data arrives later
      startReq(1'b0, 2'b00, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b1, 2, "get_blk");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         chk("getblk_stall_ack", 32'(cwb_ack_o), 32'd0);
      end
      pushRx(1'b0, 32'hA5A5A5A5);
      waitAck(10);

      // Asynchronous reset while stalled in WAIT with TX entries queued
      startReq(1'b1, 2'b00, 32'h01010101, 1'b0, 32'h0, 1'b0, 2, "pre_rst0");
      waitAck(10);
      startReq(1'b1, 2'b00, 32'h02020202, 1'b0, 32'h0, 1'b0, 2, "pre_rst1");
      waitAck(10);
      startReq(1'b1, 2'b00, 32'h03030303, 1'b0, 32'h0, 1'b0, 2, "pre_rst2");
      waitAck(10);
      chk("prerst_txcnt", 32'(tx_cnt_o), 32'd3);
      startReq(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 2, "get_rst");
      repeat (3) @(negedge clk_i);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst_ack", 32'(cwb_ack_o), 32'd0);
      chk("arst_dat", cwb_dat_o, 32'h0);
      chk("arst_txcnt", 32'(tx_cnt_o), 32'd0);
      chk("arst_rxcnt", 32'(rx_cnt_o), 32'd0);
      chk("arst_txvld", 32'(tx_vld_o), 32'd0);
      chk("arst_rxrdy", 32'(rx_rdy_o), 32'd1);
      void'(sb.pop_front());
      txExp.delete();
      cwb_stb_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Fresh put after reset
      startReq(1'b1, 2'b10, 32'hCAFEF00D, 1'b0, 32'h0, 1'b0, 2, "put_after_rst");
      waitAck(10);
      chk("postrst_txcnt", 32'(tx_cnt_o), 32'd1);
      chk("postrst_txdat", tx_dat_o, 32'hCAFEF00D);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
